// File: rtl/shared_pkg.sv
// Shared constants and types for the blocks around the team's synchronous FIFO.
package shared_pkg;

    localparam int FIFO_WIDTH   = 16;
    localparam int FIFO_DEPTH   = 8;

    localparam int NUM_REQ      = 4;
    localparam int MAX_BURST    = 4;
    localparam int IDLE_TIMEOUT = 3;
    localparam int REQ_IDX_W    = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first set req_valid bit at or
// after ptr, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter  int NUM_REQ = shared_pkg::NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);
    import shared_pkg::*;

    int cand;

    // NOTE: every output gets a default before the loop, so no path through this block infers a latch.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        // Scan from the farthest offset to the nearest so the nearest valid requester is the last write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one FIFO write port among NUM_REQ valid/ready
// producers; a grant ends on last, on a beat limit, or after an idle timeout.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ      = shared_pkg::NUM_REQ,
    parameter  int MAX_BURST    = shared_pkg::MAX_BURST,
    parameter  int IDLE_TIMEOUT = shared_pkg::IDLE_TIMEOUT,
    localparam int DW           = shared_pkg::FIFO_WIDTH,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  fifo_full,
    input  logic                  fifo_almostfull,
    output logic                  fifo_wr_en,
    output logic [DW-1:0]         fifo_data_in,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_id,
    output logic [31:0]           beat_count
);
    import shared_pkg::*;

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic               owner_last;
    logic [DW-1:0]      owner_data;
    logic               slot_free;
    logic               accept;
    logic               release_grant;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid (req_valid),
        .ptr       (rr_ptr),
        .found     (pick_found),
        .index     (pick_idx)
    );

    always_comb begin
        owner_valid = req_valid[grant_id];
        owner_last  = req_last[grant_id];
        owner_data  = req_data[int'(grant_id)*DW +: DW];
        // A write already in flight into the last free slot counts as occupying it.
        slot_free   = !rst && !fifo_full && !(fifo_almostfull && fifo_wr_en);
        accept      = (state == BURST) && owner_valid && slot_free;
        req_ready   = '0;
        if (state == BURST && slot_free) req_ready[grant_id] = 1'b1;
        release_grant = (accept && (owner_last || burst_cnt == BURST_W'(MAX_BURST - 1)))
                     || (state == BURST && !owner_valid && idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            idle_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            beat_count   <= '0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_data_in <= owner_data;
                beat_count   <= beat_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_idx;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                        idle_cnt    <= '0;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if (release_grant) begin
                        rr_ptr      <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                        grant_valid <= 1'b0;
                        burst_cnt   <= '0;
                        idle_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        if (accept) burst_cnt <= burst_cnt + BURST_W'(1);
                        // Only the owner dropping valid counts; a full FIFO with valid held does not.
                        idle_cnt <= owner_valid ? '0 : idle_cnt + IDLE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: bench-side producers and FIFO model,
// a rule-level grant model, and a decoupled write monitor.
module tb_fifo_wr_arbiter;
    import shared_pkg::*;

    localparam int N     = NUM_REQ;
    localparam int W     = FIFO_WIDTH;
    localparam int MB    = MAX_BURST;
    localparam int IT    = IDLE_TIMEOUT;
    localparam int DEPTH = FIFO_DEPTH;
    localparam int IW    = REQ_IDX_W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_almostfull;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           grant_valid;
    logic [IW-1:0]  grant_id;
    logic [31:0]    beat_count;

    fifo_wr_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .beat_count      (beat_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producers: per-requester beat stores {last, data}, consumed on handshake.
    logic [W:0] src_mem [N][256];
    int         head [N];
    int         tail [N];
    int         data_seq = 0;
    int         pres_pct = 100;
    logic [N-1:0] acc_seen = '0;

    task automatic push_beat(input int i, input logic [W-1:0] d, input bit last);
        src_mem[i][tail[i] % 256] = {last, d};
        tail[i]++;
    endtask

    function automatic logic [W-1:0] next_data(input int i);
        data_seq++;
        return {4'(i), 12'(data_seq)};
    endfunction

    // FIFO occupancy model; flags follow the count, reads drain at rd_pct.
    int fifo_cnt = 0;
    int rd_pct   = 0;
    bit wr_seen  = 1'b0;
    assign fifo_full       = (fifo_cnt == DEPTH);
    assign fifo_almostfull = (fifo_cnt == DEPTH - 1);

    task automatic step();
        int nc;
        @(posedge clk);
        #1;
        nc = fifo_cnt;
        if (wr_seen && fifo_cnt < DEPTH) nc++;
        if (fifo_cnt > 0 && $urandom_range(99) < rd_pct) nc--;
        fifo_cnt = nc;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i]) begin
                head[i]++;
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && head[i] != tail[i] && $urandom_range(99) < pres_pct)
                req_valid[i] = 1'b1;
            {req_last[i], req_data[i*W +: W]} = src_mem[i][head[i] % 256];
        end
    endtask

    // Reference model: grant ownership from the round-robin and release rules.
    bit          m_gv    = 1'b0;
    bit          m_wr    = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_burst = 0;
    int          m_idle  = 0;
    logic [31:0] m_beats = '0;
    logic [W-1:0] exp_q [$];

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic model_cycle();
        bit           ok;
        bit           acc;
        bit           rel;
        logic [N-1:0] exp_ready;
        acc_seen = req_valid & req_ready;
        wr_seen  = fifo_wr_en;
        acc      = 1'b0;
        if (checking) begin
            check("grant_valid", grant_valid, m_gv);
            if (m_gv) check("grant_id", grant_id, m_owner);
            check("beat_count", beat_count, m_beats);
            check("fifo_wr_en", fifo_wr_en, m_wr);
            ok = !rst && !fifo_full && !(fifo_almostfull && m_wr);
            exp_ready = '0;
            if (m_gv && ok) exp_ready[m_owner] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            acc = m_gv && ok && req_valid[m_owner];
            if (acc) begin
                exp_q.push_back(req_data[m_owner*W +: W]);
                m_beats++;
            end
        end
        m_wr = acc;
        if (rst) begin
            m_gv = 1'b0; m_ptr = 0; m_owner = 0; m_burst = 0; m_idle = 0; m_beats = '0; m_wr = 1'b0;
        end else if (!m_gv) begin
            if (req_valid != '0) begin
                m_owner = rr_pick(req_valid, m_ptr);
                m_gv = 1'b1; m_burst = 0; m_idle = 0;
            end
        end else begin
            rel = (acc && (req_last[m_owner] || m_burst == MB - 1))
               || (!req_valid[m_owner] && m_idle + 1 == IT);
            if (acc) m_burst++;
            m_idle = req_valid[m_owner] ? 0 : m_idle + 1;
            if (rel) begin
                m_gv = 1'b0; m_ptr = (m_owner + 1) % N; m_burst = 0; m_idle = 0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_cycle();
    end

    // Monitor: pops an expected beat whenever the DUT writes; logs grant starts.
    int seen_q [$];
    bit prev_gv = 1'b0;

    initial forever begin
        @(negedge clk);
        if (checking) begin
            if (fifo_wr_en === 1'b1) begin
                check("wr_while_full", fifo_full, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_write: got data %0h, expected no write at %0t", fifo_data_in, $time);
                end else begin
                    check("fifo_data_in", fifo_data_in, exp_q.pop_front());
                end
            end
            if (grant_valid && !prev_gv) seen_q.push_back(int'(grant_id));
            prev_gv = grant_valid;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fifo_cnt = 0;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (head[i] != tail[i]) return 1'b0;
        return (req_valid == '0) && (exp_q.size() == 0) && !grant_valid && !fifo_wr_en;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        rd_pct   = 100;
        pres_pct = 100;
        while (n < 300 && !all_idle()) begin
            step();
            n++;
        end
        check({name, "_drained"}, n < 300, 1);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        step();
        step();
        rst = 1'b0;
        checking = 1'b1;
        step();
        check("reset_grant_id", grant_id, 0);
        check("reset_data_in", fifo_data_in, 0);

        // Three-beat burst from requester 0 into an empty FIFO.
        rd_pct = 0;
        push_beat(0, 16'h0001, 1'b0);
        push_beat(0, 16'h0002, 1'b0);
        push_beat(0, 16'h0004, 1'b1);
        seen_q.delete();
        run(10);
        check("t1_beat_count", beat_count, 3);
        check("t1_fifo_cnt", fifo_cnt, 3);
        check("t1_grants", seen_q.size(), 1);
        drain("t1");

        // All requesters continuously valid with single-beat bursts.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 3; b++) push_beat(i, next_data(i), 1'b1);
        seen_q.delete();
        rd_pct = 100;
        run(11);
        check("t2_grant_count", seen_q.size(), 5);
        for (int k = 0; k < 5 && k < seen_q.size(); k++)
            check($sformatf("t2_grant_%0d", k), seen_q[k], k % N);
        drain("t2");

        // Requester 2 streams six beats without last.
        do_reset();
        for (int b = 0; b < 6; b++) push_beat(2, next_data(2), 1'b0);
        seen_q.delete();
        drain("t3");
        check("t3_grants", seen_q.size(), 2);
        for (int k = 0; k < 2 && k < seen_q.size(); k++)
            check($sformatf("t3_owner_%0d", k), seen_q[k], 2);

        // FIFO one entry short of full, no reads.
        do_reset();
        fifo_cnt = DEPTH - 1;
        rd_pct = 0;
        for (int b = 0; b < 4; b++) push_beat(1, next_data(1), b == 3);
        run(15);
        check("t4_beats_while_full", beat_count, 1);
        check("t4_fifo_cnt", fifo_cnt, DEPTH);
        check("t4_ready_blocked", req_ready, 0);
        drain("t4");
        check("t4_beats_total", beat_count, 4);

        // Owner 1 goes idle mid-burst while requester 3 waits.
        do_reset();
        push_beat(1, next_data(1), 1'b0);
        push_beat(3, next_data(3), 1'b1);
        seen_q.delete();
        drain("t5");
        check("t5_grants", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("t5_first", seen_q[0], 1);
            check("t5_second", seen_q[1], 3);
        end

        // Reset pulsed during beat 2 of a four-beat burst.
        do_reset();
        rd_pct = 100;
        for (int b = 0; b < 4; b++) push_beat(0, next_data(0), b == 3);
        begin
            int n;
            n = 0;
            while (beat_count != 1 && n < 20) begin
                step();
                n++;
            end
            check("t6_first_beat", n < 20, 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        fifo_cnt = 0;
        check("t6_grant_valid", grant_valid, 0);
        check("t6_grant_id", grant_id, 0);
        check("t6_wr_en", fifo_wr_en, 0);
        check("t6_data_in", fifo_data_in, 0);
        check("t6_beat_count", beat_count, 0);
        check("t6_ready", req_ready, 0);
        seen_q.delete();
        drain("t6");
        check("t6_regrant", seen_q.size() > 0 ? seen_q[0] : -1, 0);
        check("t6_beats_after", beat_count, 3);

        // Randomized traffic with varying read rate and producer gaps.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                rd_pct   = $urandom_range(20, 100);
                pres_pct = $urandom_range(40, 100);
            end
            for (int i = 0; i < N; i++)
                if (tail[i] - head[i] < 8 && $urandom_range(99) < 25)
                    push_beat(i, next_data(i), $urandom_range(2) == 0);
            step();
        end
        drain("random");
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port scheduler placed in front of the team's synchronous FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8).
- Shares the single FIFO write port among NUM_REQ producers using valid/ready handshakes.
- Each grant covers a burst that ends on a last flag, a beat limit or an idle timeout.
- The block drives wr_en/data_in on registered outputs and uses the FIFO full/almostfull flags for backpressure, so it never causes an overflow.

Parameters:
- FIFO_WIDTH, 16, data width; taken from the shared package.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant (1..FIFO_DEPTH).
- IDLE_TIMEOUT, 3, consecutive cycles the owner may hold valid low before its grant is released.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  packed beat data; requester i occupies bits [i*W +: W].
- req_last  in  NUM_REQ  final beat of burst.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO flag: count == FIFO_DEPTH-1.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_data_in  out  FIFO_WIDTH  registered FIFO write data.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  $clog2(NUM_REQ)  index of the owner.
- beat_count  out  32  total beats accepted since reset; wraps at 2^32.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; fifo_wr_en=0; fifo_data_in=0; grant_valid=0; grant_id=0; beat_count=0.
  - rr_ptr=0; burst and idle counters=0; req_ready=0.
  - Reset mid-burst aborts the burst. The in-flight fifo_wr_en is cleared, so no write occurs on the following cycle.
- FSM, IDLE:
  - req_ready=0.
  - If any req_valid is set, select the first valid index searching from rr_ptr upward, modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, go to BURST. Arbitration latency is 1 cycle.
- FSM, BURST:
  - Only req_ready[grant_id] may be high.
  - accept = req_valid[grant_id] & req_ready[grant_id].
  - req_ready[grant_id] = !fifo_full & !(fifo_almostfull & fifo_wr_en). This is conservative: a write already in flight into the last free slot blocks acceptance.
  - On accept, the next cycle has fifo_wr_en=1, fifo_data_in=that beat, and beat_count+1. Without an accept, fifo_wr_en=0 next cycle. Write latency is 1 cycle.
  - The burst counter increments on each accept.
  - Release when any of these occur:
    - accept with req_last;
    - accept with burst counter == MAX_BURST-1;
    - idle counter reaches IDLE_TIMEOUT.
  - The idle counter counts cycles with req_valid[grant_id]=0 and resets on any owner valid. Backpressure from FIFO full does not count toward the timeout.
  - On release: rr_ptr=(grant_id+1) mod NUM_REQ, grant_valid=0, counters cleared, go to IDLE. There is a minimum 1-cycle IDLE gap between grants.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- Ungranted requesters must hold req_valid and data stable until accepted; the arbiter never drops data.
- The block never asserts fifo_wr_en in a cycle where fifo_full is high.
- Valid/last on requesters that are not the owner are ignored.

Decomposition:
- Add to shared_pkg:
  - NUM_REQ, MAX_BURST, IDLE_TIMEOUT defaults;
  - typedef enum logic {IDLE, BURST} arb_state_e;
  - derived constant REQ_IDX_W=$clog2(NUM_REQ).
- One sub-module, rr_picker: combinational. Takes req_valid and rr_ptr, returns found and index.

Test Plan:
- Requester 0 sends 3 beats 16'h0001,16'h0002,16'h0004 with last on beat 3; FIFO empty.
  - grant_id=0 one cycle after valid.
  - fifo_wr_en high for 3 consecutive cycles with that data.
  - beat_count=3; back to IDLE.
- All 4 requesters valid continuously, single-beat bursts.
  - grant_id sequence is 0,1,2,3,0 with one IDLE cycle between grants.
  - Each requester gets 1 beat per 8 cycles.
- Requester 2 streams 6 beats with no last, MAX_BURST=4.
  - Released after 4 beats; 4 writes then grant drops.
  - Re-granted on the next arbitration if it is the only valid requester.
- FIFO prefilled to 7 entries (almostfull=1), no reads.
  - Exactly 1 further write is issued; fifo_full never coincides with fifo_wr_en.
  - req_ready stays 0 until a read clears full.
- Owner 1 drops valid for 3 cycles mid-burst.
  - Grant released and rr_ptr=2.
  - A pending requester 3 is granted next (search order 2,3).
- rst=1 pulsed during beat 2 of a 4-beat burst.
  - Next cycle all outputs are 0 and no write occurs.
  - After reset, a fresh grant starts from rr_ptr=0.
